// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - N-bit unsigned up/down counter that clamps at 0 and 2^N-1, with preset load
`timescale 1ns/1ps
module sat_counter #(
    parameter int          N       = 8,
    parameter int unsigned SET_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         setval,
    output logic [N-1:0] value
);

    localparam logic [N-1:0] MAX_CNT = {N{1'b1}};
    localparam logic [N-1:0] SET_CNT = N'(SET_VAL);

    if (N < 1 || N > 32) begin : g_bad_width
        $error("sat_counter: N=%0d outside 1..32", N);
    end

    if (64'(SET_VAL) > ((64'd1 << N) - 64'd1)) begin : g_bad_set_val
        $error("sat_counter: SET_VAL=%0d does not fit in %0d bits", SET_VAL, N);
    end

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    // Limits are checked against constants so the increment never needs a carry bit.
    always_comb begin
        cnt_d = cnt_q;
        if (setval) begin
            cnt_d = SET_CNT;
        end else if (inc && !dec) begin
            if (cnt_q != MAX_CNT) begin
                cnt_d = cnt_q + N'(1);
            end
        end else if (dec && !inc) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - N'(1);
            end
        end
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;

endmodule

// File: tb/tb_sat_counter.sv
// tb/tb_sat_counter.sv - directed and randomised checks of sat_counter at 2, 8 and 16 bits
`timescale 1ns/1ps
module tb_sat_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2 = 1'b0, set2 = 1'b0, inc2 = 1'b0, dec2 = 1'b0;
    logic        rst8 = 1'b0, set8 = 1'b0, inc8 = 1'b0, dec8 = 1'b0;
    logic        rst16 = 1'b0, set16 = 1'b0, inc16 = 1'b0, dec16 = 1'b0;
    logic [1:0]  v2;
    logic [7:0]  v8;
    logic [15:0] v16;

    int tests_run    = 0;
    int tests_failed = 0;

    sat_counter #(.N(2), .SET_VAL(2)) u_cnt2 (
        .clk(clk), .rst_n(rst2), .inc(inc2), .dec(dec2), .setval(set2), .value(v2)
    );
    sat_counter #(.N(8), .SET_VAL(200)) u_cnt8 (
        .clk(clk), .rst_n(rst8), .inc(inc8), .dec(dec8), .setval(set8), .value(v8)
    );
    sat_counter #(.N(16), .SET_VAL(1000)) u_cnt16 (
        .clk(clk), .rst_n(rst16), .inc(inc16), .dec(dec16), .setval(set16), .value(v16)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: priority reset > setval > cancel > inc (clamp) > dec (clamp).
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] maxv,
                                             input logic [31:0] preset, input logic r,
                                             input logic s, input logic i, input logic d);
        if (r) return 32'd0;
        if (s) return preset;
        if (i && d) return cur;
        if (i) return (cur >= maxv) ? maxv : cur + 32'd1;
        if (d) return (cur == 32'd0) ? 32'd0 : cur - 32'd1;
        return cur;
    endfunction

    function automatic logic step_ok(input logic [31:0] prev, input logic [31:0] now,
                                     input logic [31:0] maxv, input logic r, input logic s);
        logic [31:0] diff;
        diff = (now > prev) ? now - prev : prev - now;
        return (now <= maxv) && (r || s || diff <= 32'd1);
    endfunction

    int e2[6]  = '{1, 2, 3, 3, 3, 3};
    int e2d[5] = '{2, 1, 0, 0, 0};

    initial begin
        logic [31:0] exp2, exp8, exp16, p2, p8, p16;

        // Reset all three counters for one edge.
        rst2 = 1'b1; rst8 = 1'b1; rst16 = 1'b1;
        step();
        rst2 = 1'b0; rst8 = 1'b0; rst16 = 1'b0;
        check("reset_n2", 32'(v2), 32'd0);
        check("reset_n8", 32'(v8), 32'd0);
        check("reset_n16", 32'(v16), 32'd0);

        // N=8: five increments from zero.
        inc8 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("inc5_n8_%0d", k), 32'(v8), 32'(k));
        end
        inc8 = 1'b0;

        // N=2: climb into the top clamp, then fall into the bottom clamp.
        inc2 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("sat_hi_n2_%0d", k), 32'(v2), 32'(e2[k]));
        end
        inc2 = 1'b0;
        dec2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("sat_lo_n2_%0d", k), 32'(v2), 32'(e2d[k]));
        end
        dec2 = 1'b0;

        // N=8: preset 200, then 60 increments clamp at 255 without wrapping.
        set8 = 1'b1;
        step();
        set8 = 1'b0;
        check("setval_n8", 32'(v8), 32'd200);
        inc8 = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            check($sformatf("sat_hi_n8_%0d", k), 32'(v8), (200 + k > 255) ? 32'd255 : 32'(200 + k));
        end
        inc8 = 1'b0;

        // N=16: setval overrides inc; inc with dec cancels.
        set16 = 1'b1; inc16 = 1'b1;
        step();
        set16 = 1'b0;
        check("setval_over_inc_n16", 32'(v16), 32'd1000);
        dec16 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("cancel_n16_%0d", k), 32'(v16), 32'd1000);
        end
        dec16 = 1'b0;

        // N=16: reset beats a simultaneous inc, then counting resumes.
        rst16 = 1'b1; set16 = 1'b1;
        step();
        rst16 = 1'b0; set16 = 1'b0;
        check("rst_over_inc_n16", 32'(v16), 32'd0);
        step();
        check("resume_after_rst_n16", 32'(v16), 32'd1);
        inc16 = 1'b0;

        // Random phase against the reference model.
        exp2 = 32'(v2); exp8 = 32'(v8); exp16 = 32'(v16);
        for (int c = 0; c < 10000; c++) begin
            rst2  = ($urandom_range(0, 99) == 0); set2  = ($urandom_range(0, 19) == 0);
            inc2  = 1'($urandom); dec2  = 1'($urandom);
            rst8  = ($urandom_range(0, 99) == 0); set8  = ($urandom_range(0, 19) == 0);
            inc8  = 1'($urandom); dec8  = 1'($urandom);
            rst16 = ($urandom_range(0, 99) == 0); set16 = ($urandom_range(0, 19) == 0);
            inc16 = ($urandom_range(0, 3) != 0); dec16 = 1'($urandom);
            p2 = exp2; p8 = exp8; p16 = exp16;
            exp2  = ref_next(p2, 32'd3, 32'd2, rst2, set2, inc2, dec2);
            exp8  = ref_next(p8, 32'd255, 32'd200, rst8, set8, inc8, dec8);
            exp16 = ref_next(p16, 32'd65535, 32'd1000, rst16, set16, inc16, dec16);
            step();
            check($sformatf("rand_n2_%0d", c), 32'(v2), exp2);
            check($sformatf("rand_n8_%0d", c), 32'(v8), exp8);
            check($sformatf("rand_n16_%0d", c), 32'(v16), exp16);
            check($sformatf("bound_n2_%0d", c), 32'(step_ok(p2, 32'(v2), 32'd3, rst2, set2)), 32'd1);
            check($sformatf("bound_n8_%0d", c), 32'(step_ok(p8, 32'(v8), 32'd255, rst8, set8)), 32'd1);
            check($sformatf("bound_n16_%0d", c), 32'(step_ok(p16, 32'(v16), 32'd65535, rst16, set16)), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
